pipelined_hit_detector: RTL and testbench

//  Two-stage pipelined successor to the combinational set hit detector for the L2 simulator.

---
 rtl/pipelined_hit_detector_pkg.sv | 17 +
 rtl/pipelined_hit_detector_way_select_encoder.sv | 23 ++
 rtl/pipelined_hit_detector.sv | 177 +++++++++++++++++
 tb/tb_pipelined_hit_detector.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_hit_detector_pkg.sv
// Shared defaults and small types for the pipelined set hit detector.
package pipelined_hit_detector_pkg;

  // Default geometry of the L2 set being searched
  localparam int unsigned WAYS_DEFAULT      = 8;
  localparam int unsigned TAG_BITS_DEFAULT  = 10;
  localparam int unsigned LINE_BITS_DEFAULT = 512;
  localparam int unsigned CNT_BITS_DEFAULT  = 32;

  // Where the replacement victim of a lookup comes from
  typedef enum logic [1:0] {
    VICTIM_HIT     = 2'd0,
    VICTIM_INVALID = 2'd1,
    VICTIM_RR      = 2'd2
  } victim_src_e;

endpackage : pipelined_hit_detector_pkg

// File: rtl/pipelined_hit_detector_way_select_encoder.sv
// Multi-hot vector -> lowest set index, any-set and more-than-one-set flags.
module way_select_encoder #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0]         vec,
  output logic [$clog2(N)-1:0] idx_c,
  output logic                 any_c,
  output logic                 multi_c
);

  localparam int unsigned IDX_BITS = $clog2(N);

  // Priority encode towards the lowest index; clearing the lowest set bit detects a second one
  always_comb begin
    idx_c = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (vec[i]) idx_c = IDX_BITS'(i);
    end
    any_c   = |vec;
    multi_c = |(vec & (vec - N'(1)));
  end

endmodule : way_select_encoder

// File: rtl/pipelined_hit_detector.sv
// Two-stage pipelined tag lookup of one cache set with valid/ready flow control,
// replacement victim selection and saturating hit/miss statistics.
module pipelined_hit_detector
  import pipelined_hit_detector_pkg::*;
#(
  parameter int unsigned WAYS      = WAYS_DEFAULT,
  parameter int unsigned TAG_BITS  = TAG_BITS_DEFAULT,
  parameter int unsigned LINE_BITS = LINE_BITS_DEFAULT,
  parameter int unsigned CNT_BITS  = CNT_BITS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [TAG_BITS-1:0]        addressTag,
  input  logic [WAYS-1:0]            valid,
  input  logic [TAG_BITS*WAYS-1:0]   cacheTag,
  input  logic [LINE_BITS*WAYS-1:0]  cacheData,
  output logic                       outValid,
  input  logic                       outReady,
  output logic                       hit,
  output logic [$clog2(WAYS)-1:0]    hitWay,
  output logic [LINE_BITS-1:0]       cacheLine,
  output logic                       multiHit,
  output logic [$clog2(WAYS)-1:0]    victimWay,
  input  logic                       clearStats,
  output logic [CNT_BITS-1:0]        hitCount,
  output logic [CNT_BITS-1:0]        missCount
);

  localparam int unsigned WAY_BITS = $clog2(WAYS);

  // Pipeline control
  logic en1;
  logic en2;
  logic out_fire;

  // Stage 1 state
  logic                      s1_valid;
  logic [WAYS-1:0]           s1_match;
  logic [WAYS-1:0]           s1_valid_vec;
  logic [LINE_BITS*WAYS-1:0] s1_data;

  // Stage 1 compare result
  logic [WAYS-1:0] tag_match_c;

  // Stage 2 combinational result
  logic [WAY_BITS-1:0]  match_idx;
  logic                 match_any;
  logic                 match_multi;
  logic [WAYS-1:0]      invalid_vec;
  logic [WAY_BITS-1:0]  inv_idx;
  logic                 inv_any;
  logic                 inv_multi_unused;
  logic [LINE_BITS-1:0] sel_line_c;
  logic [WAY_BITS-1:0]  victim_c;
  victim_src_e          victim_src;
  logic                 rr_advance_c;

  // Round-robin victim pointer for fully valid sets
  logic [WAY_BITS-1:0] rr_ptr;

  // Stage 2 may load when its result is empty or being consumed; stage 1 when stage 2 can take it
  assign en2      = !outValid || outReady;
  assign en1      = !s1_valid || en2;
  assign inReady  = en1;
  assign out_fire = outValid && outReady;

  // Per-way tag compare, masked by the way's valid bit
  always_comb begin
    tag_match_c = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      tag_match_c[i] = valid[i] && (cacheTag[i*TAG_BITS +: TAG_BITS] == addressTag);
    end
  end

  // Stage 1 control and compare registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid     <= 1'b0;
      s1_match     <= '0;
      s1_valid_vec <= '0;
    end else if (en1) begin
      s1_valid     <= inValid;
      s1_match     <= tag_match_c;
      s1_valid_vec <= valid;
    end
  end

  // Stage 1 line data; never observed unless it is a hit, so it needs no reset
  always_ff @(posedge clk) begin
    if (en1) s1_data <= cacheData;
  end

  way_select_encoder #(.N(WAYS)) u_hit_enc (
    .vec     (s1_match),
    .idx_c   (match_idx),
    .any_c   (match_any),
    .multi_c (match_multi)
  );

  assign invalid_vec = ~s1_valid_vec;

  way_select_encoder #(.N(WAYS)) u_inv_enc (
    .vec     (invalid_vec),
    .idx_c   (inv_idx),
    .any_c   (inv_any),
    .multi_c (inv_multi_unused)
  );

  // Select the hit line; a miss returns all zeros
  always_comb begin
    sel_line_c = '0;
    if (match_any) sel_line_c = s1_data[32'(match_idx)*LINE_BITS +: LINE_BITS];
  end

  // Victim: the hit way, else the lowest free way, else the round-robin pointer
  always_comb begin
    victim_src = VICTIM_RR;
    if (match_any)    victim_src = VICTIM_HIT;
    else if (inv_any) victim_src = VICTIM_INVALID;
    victim_c = rr_ptr;
    unique case (victim_src)
      VICTIM_HIT:     victim_c = match_idx;
      VICTIM_INVALID: victim_c = inv_idx;
      default:        victim_c = rr_ptr;
    endcase
  end

  // Pointer steps when a fully valid miss enters the output stage. Results leave in order and
  // are never dropped, so this gives each delivered miss the same victim as stepping on delivery,
  // and a result loaded on the same edge another is consumed still sees the advanced pointer.
  assign rr_advance_c = en2 && s1_valid && !match_any && !inv_any;

  // Round-robin pointer, wrapping naturally since WAYS is a power of two
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (rr_advance_c) begin
      rr_ptr <= rr_ptr + WAY_BITS'(1);
    end
  end

  // Stage 2 output registers, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outValid  <= 1'b0;
      hit       <= 1'b0;
      hitWay    <= '0;
      cacheLine <= '0;
      multiHit  <= 1'b0;
      victimWay <= '0;
    end else if (en2) begin
      outValid  <= s1_valid;
      hit       <= match_any;
      hitWay    <= match_idx;
      cacheLine <= sel_line_c;
      multiHit  <= match_multi;
      victimWay <= victim_c;
    end
  end

  // Saturating statistics on delivered results; clear takes priority over counting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hitCount  <= '0;
      missCount <= '0;
    end else if (clearStats) begin
      hitCount  <= '0;
      missCount <= '0;
    end else if (out_fire) begin
      if (hit && (hitCount != '1))   hitCount  <= hitCount + CNT_BITS'(1);
      if (!hit && (missCount != '1)) missCount <= missCount + CNT_BITS'(1);
    end
  end

endmodule : pipelined_hit_detector

// File: tb/tb_pipelined_hit_detector.sv
// Self-checking bench for pipelined_hit_detector: vector table plus scoreboard queue.
module tb_pipelined_hit_detector;

  typedef struct {
    logic [9:0] tag;
    logic [7:0] vld;
    logic [7:0] mask;
    logic       ehit;
    logic [2:0] eway;
    logic       emulti;
    logic [2:0] evict;
  } vec_t;

  typedef struct {
    logic         hit;
    logic [2:0]   way;
    logic [511:0] line;
    logic         multi;
    logic [2:0]   victim;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           out_ready;
  logic           clear_stats;
  logic [9:0]     address_tag;
  logic [7:0]     valid_bits;
  logic [79:0]    cache_tag;
  logic [4095:0]  cache_data;

  logic           in_ready, out_valid, hit, multi_hit;
  logic [2:0]     hit_way, victim_way;
  logic [511:0]   cache_line;
  logic [31:0]    hit_count, miss_count;

  logic           s_in_ready, s_out_valid, s_hit, s_multi_hit;
  logic [2:0]     s_hit_way, s_victim_way;
  logic [511:0]   s_cache_line;
  logic [3:0]     s_hit_count, s_miss_count;

  int    checks;
  int    failures;
  exp_t  q[$];
  exp_t  pend;
  int    stall_left;
  logic  last_in_fire;
  logic  was_stalled;
  logic  snap_hit, snap_multi;
  logic [2:0] snap_way, snap_victim;
  logic [511:0] snap_line;
  int    m_hit, m_miss;
  logic [3:0] ms_hit, ms_miss;
  logic [2:0] m_rr;
  vec_t  vecs[8];

  pipelined_hit_detector dut (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(in_ready),
    .addressTag(address_tag), .valid(valid_bits), .cacheTag(cache_tag), .cacheData(cache_data),
    .outValid(out_valid), .outReady(out_ready), .hit(hit), .hitWay(hit_way),
    .cacheLine(cache_line), .multiHit(multi_hit), .victimWay(victim_way),
    .clearStats(clear_stats), .hitCount(hit_count), .missCount(miss_count)
  );

  pipelined_hit_detector #(.CNT_BITS(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .inValid(in_valid), .inReady(s_in_ready),
    .addressTag(address_tag), .valid(valid_bits), .cacheTag(cache_tag), .cacheData(cache_data),
    .outValid(s_out_valid), .outReady(out_ready), .hit(s_hit), .hitWay(s_hit_way),
    .cacheLine(s_cache_line), .multiHit(s_multi_hit), .victimWay(s_victim_way),
    .clearStats(clear_stats), .hitCount(s_hit_count), .missCount(s_miss_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_line(input int seed, input int way);
    logic [31:0] w;
    w = 32'hA500_0000 | 32'(seed << 8) | 32'(way);
    return {16{w}};
  endfunction

  // One cycle: set outReady, check at negedge+1, account handshakes for the coming posedge
  task automatic step();
    exp_t e;
    logic out_fire;
    out_ready = (stall_left == 0);
    if (stall_left > 0) stall_left--;
    #1;
    if (was_stalled) begin
      chk("stall_hit", hit, snap_hit);
      chk("stall_way", hit_way, snap_way);
      chk("stall_line", cache_line, snap_line);
      chk("stall_multi", multi_hit, snap_multi);
      chk("stall_victim", victim_way, snap_victim);
      chk("stall_valid", out_valid, 1'b1);
    end
    chk("hit_count", hit_count, 32'(m_hit));
    chk("miss_count", miss_count, 32'(m_miss));
    chk("sat_hit_count", s_hit_count, ms_hit);
    chk("sat_miss_count", s_miss_count, ms_miss);
    last_in_fire = in_valid && in_ready;
    out_fire     = out_valid && out_ready;
    if (out_fire) begin
      if (q.size() == 0) begin
        chk("unexpected_result", out_valid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("res_hit", hit, e.hit);
        chk("res_way", hit_way, e.way);
        chk("res_line", cache_line, e.line);
        chk("res_multi", multi_hit, e.multi);
        chk("res_victim", victim_way, e.victim);
        if (e.hit) begin
          m_hit++;
          if (ms_hit != 4'hF) ms_hit = ms_hit + 4'd1;
        end else begin
          m_miss++;
          if (ms_miss != 4'hF) ms_miss = ms_miss + 4'd1;
        end
      end
    end
    if (clear_stats) begin
      m_hit = 0; m_miss = 0; ms_hit = 4'd0; ms_miss = 4'd0;
    end
    if (last_in_fire) q.push_back(pend);
    was_stalled = out_valid && !out_ready;
    snap_hit    = hit;
    snap_way    = hit_way;
    snap_line   = cache_line;
    snap_multi  = multi_hit;
    snap_victim = victim_way;
    @(negedge clk);
  endtask

  task automatic issue(input logic [9:0] tag, input logic [7:0] vld, input logic [7:0] mask,
                       input int seed, input exp_t e);
    logic accepted;
    address_tag = tag;
    valid_bits  = vld;
    for (int i = 0; i < 8; i++) begin
      cache_tag[i*10 +: 10]    = mask[i] ? tag : (tag ^ 10'(i + 1));
      cache_data[i*512 +: 512] = make_line(seed, i);
    end
    pend     = e;
    in_valid = 1'b1;
    accepted = 1'b0;
    for (int n = 0; n < 50 && !accepted; n++) begin
      step();
      accepted = last_in_fire;
    end
    in_valid = 1'b0;
    chk("issue_accept", accepted, 1'b1);
  endtask

  task automatic issue_vec(input vec_t v, input int seed);
    exp_t e;
    e.hit    = v.ehit;
    e.way    = v.eway;
    e.line   = v.ehit ? make_line(seed, int'(v.eway)) : 512'd0;
    e.multi  = v.emulti;
    e.victim = v.evict;
    issue(v.tag, v.vld, v.mask, seed, e);
  endtask

  task automatic drain();
    for (int n = 0; n < 100 && q.size() > 0; n++) step();
    chk("drain_empty", 32'(q.size()), 32'd0);
    step();
  endtask

  initial begin
    checks = 0; failures = 0;
    stall_left = 0; was_stalled = 1'b0; last_in_fire = 1'b0;
    m_hit = 0; m_miss = 0; ms_hit = 4'd0; ms_miss = 4'd0; m_rr = 3'd0;
    snap_hit = 1'b0; snap_way = 3'd0; snap_line = '0; snap_multi = 1'b0; snap_victim = 3'd0;
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; clear_stats = 1'b0;
    address_tag = '0; valid_bits = '0; cache_tag = '0; cache_data = '0;

    //            tag     valid  mask   hit   way   multi victim
    vecs[0] = '{10'h2A3, 8'hFF, 8'h20, 1'b1, 3'd5, 1'b0, 3'd5};
    vecs[1] = '{10'h2A3, 8'hDF, 8'h20, 1'b0, 3'd0, 1'b0, 3'd5};
    vecs[2] = '{10'h155, 8'hFF, 8'h44, 1'b1, 3'd2, 1'b1, 3'd2};
    vecs[3] = '{10'h001, 8'h80, 8'h80, 1'b1, 3'd7, 1'b0, 3'd7};
    vecs[4] = '{10'h3FF, 8'h00, 8'hFF, 1'b0, 3'd0, 1'b0, 3'd0};
    vecs[5] = '{10'h0AA, 8'hF0, 8'h0F, 1'b0, 3'd0, 1'b0, 3'd0};
    vecs[6] = '{10'h123, 8'hFE, 8'h01, 1'b0, 3'd0, 1'b0, 3'd0};
    vecs[7] = '{10'h200, 8'h7F, 8'h03, 1'b1, 3'd0, 1'b1, 3'd0};

    // Reset held two edges with a request pending
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_hit", hit, 1'b0);
    chk("rst_way", hit_way, 3'd0);
    chk("rst_line", cache_line, 512'd0);
    chk("rst_multi", multi_hit, 1'b0);
    chk("rst_victim", victim_way, 3'd0);
    chk("rst_hit_count", hit_count, 32'd0);
    chk("rst_miss_count", miss_count, 32'd0);
    @(negedge clk);

    // First hit on its own: two-cycle latency, then hitCount becomes 1
    issue_vec(vecs[0], 1);
    step();
    chk("lat_out_valid", out_valid, 1'b1);
    step();
    chk("first_hit_count", hit_count, 32'd1);

    // Whole table back to back at full throughput
    for (int i = 0; i < 8; i++) issue_vec(vecs[i], 10 + i);
    drain();
    chk("table_hits", hit_count, 32'd5);
    chk("table_misses", miss_count, 32'd4);

    // Backpressure: consumer stalls three cycles while four hits are offered
    stall_left = 3;
    issue_vec(vecs[0], 20);
    issue_vec(vecs[2], 21);
    #1;
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    issue_vec(vecs[3], 22);
    issue_vec(vecs[7], 23);
    drain();

    // Nine misses in a fully valid set walk the round-robin pointer 0..7,0
    for (int i = 0; i < 9; i++) begin
      exp_t e;
      e.hit = 1'b0; e.way = 3'd0; e.line = '0; e.multi = 1'b0; e.victim = m_rr;
      m_rr = m_rr + 3'd1;
      issue(10'h0F0, 8'hFF, 8'h00, 30 + i, e);
    end
    drain();

    // Sixteen hits saturate the 4-bit counter at 15
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    for (int i = 0; i < 16; i++) issue_vec(vecs[i % 2 == 0 ? 0 : 2], 40 + i);
    drain();
    chk("sat_hit_15", s_hit_count, 4'hF);
    chk("sat_wide_16", hit_count, 32'd16);

    // Clear in the same cycle a hit is delivered leaves zero
    stall_left = 100;
    issue_vec(vecs[0], 60);
    for (int n = 0; n < 10 && !out_valid; n++) step();
    clear_stats = 1'b1;
    stall_left = 0;
    step();
    clear_stats = 1'b0;
    step();
    chk("clr_hit_count", hit_count, 32'd0);
    chk("clr_sat_hit_count", s_hit_count, 4'd0);
    chk("clr_queue_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_pipelined_hit_detector
